// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: arbiter state encoding,
// divider values for the common clock/baud pairs, and a watchdog sizing helper.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  // Clocks per bit for the attached 8N1 frame engine.
  localparam int BPS_50MHz_115200 = 434;
  localparam int BPS_50MHz_9600   = 5208;
  localparam int BPS_12MHz_115200 = 104;
  localparam int BPS_12MHz_9600   = 1250;

  // A frame is ten bit times plus a few cycles of engine handshake; the
  // watchdog must sit above that or it will abort healthy frames.
  function automatic logic [15:0] default_timeout(input int bps, input int slack);
    int total;
    total = bps * 10 + slack;
    return total[15:0];
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority encoder: scans the request vector starting one past the
// previous winner so every requester gets a turn.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic             any_o,
  output logic [ID_W-1:0]  winner_o
);

  int idx;

  // First set bit at last_grant+1, last_grant+2, ... modulo N_REQ wins.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant_i) + i) % N_REQ;
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 byte transmitter between N_REQ producers. A byte is latched
// from the round-robin winner and held with the enable for the whole frame;
// the transmitter's done pulse (or the watchdog) releases it.
//
// state | meaning
// IDLE  | transmitter free, arbitrate on any request
// SEND  | enable and byte held, waiting for done or watchdog
// GAP   | one enable-low cycle so the transmitter restarts cleanly
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CLKS = 16'd5000,
  localparam int         ID_W         = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_en_sig,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  state_t             state_q, state_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [15:0]        timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;

  logic               pick_any;
  logic [ID_W-1:0]    pick_winner;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_winner)
  );

  // Next-state and output decisions for the arbitration/frame sequence.
  always_comb begin
    state_d       = state_q;
    tx_en_d       = tx_en_q;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          tx_data_d    = req_data[{pick_winner, 3'b000} +: 8];
          tx_en_d      = 1'b1;
          req_ready_d  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_winner;
          grant_id_d   = pick_winner;
          last_grant_d = pick_winner;
          timer_d      = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        // Done has priority: a frame that completes on the deadline is good.
        if (tx_done) begin
          tx_en_d = 1'b0;
          state_d = ST_GAP;
        end else if (timer_q == TIMEOUT_CLKS - 16'd1) begin
          tx_en_d       = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register everything; reset parks the pointer so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      req_ready_q   <= '0;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(N_REQ - 1);
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_en_sig   = tx_en_q;
  assign tx_data     = tx_data_q;
  assign req_ready   = req_ready_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the transmitter is a stub whose done
// pulse is driven by hand so every edge of the sequence is predictable.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_en_sig;
  logic [7:0]         tx_data;
  logic               tx_done = 1'b0;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .TIMEOUT_CLKS (16'd100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Done pulse on the next edge, then one more edge through GAP into IDLE.
  task automatic finish_frame();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    vectors++; if (tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b exp 0", tx_en_sig); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h exp 00", tx_data); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", timeout_err); end
    rst_n = 1'b1;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single();
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    step();
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d exp 2", grant_id); end
    vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h exp a5", tx_data); end
    vectors++; if (tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL single_en: got %b exp 1", tx_en_sig); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b exp 1", busy); end
    req_valid = 4'b0000;
    req_data  = 32'hFFFF_FFFF;
    step();
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_drop: got %b exp 0000", req_ready); end
    vectors++; if (tx_data !== 8'hA5 || tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL single_hold: got en=%b data=%h exp en=1 data=a5", tx_en_sig, tx_data); end
    repeat (5) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++; if (tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL single_release: got %b exp 0", tx_en_sig); end
    vectors++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL single_gap: got busy=%b err=%b exp busy=1 err=0", busy, timeout_err); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b exp 0", busy); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++; if (busy !== 1'b0 || tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL idle_done_ignored: got busy=%b en=%b exp 0 0", busy, tx_en_sig); end
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_data  = 32'h3300_1100;
    req_valid = 4'b1010;
    step();
    vectors++; if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin miscompares++; $display("FAIL simul_first: got ready=%b id=%0d exp 0010 1", req_ready, grant_id); end
    vectors++; if (tx_data !== 8'h11) begin miscompares++; $display("FAIL simul_first_data: got %h exp 11", tx_data); end
    req_valid = 4'b1000;
    repeat (3) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++; if (tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL simul_gap1_en: got %b exp 0", tx_en_sig); end
    step();
    vectors++; if (tx_en_sig !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL simul_gap2: got en=%b ready=%b exp 0 0000", tx_en_sig, req_ready); end
    step();
    vectors++; if (req_ready !== 4'b1000 || grant_id !== 2'd3) begin miscompares++; $display("FAIL simul_second: got ready=%b id=%0d exp 1000 3", req_ready, grant_id); end
    vectors++; if (tx_data !== 8'h33 || tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL simul_second_data: got en=%b data=%h exp 1 33", tx_en_sig, tx_data); end
    req_valid = 4'b0000;
    repeat (2) step();
    finish_frame();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    int exp_id;
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      exp_id  = f % 4;
      exp_rdy = 4'b0001 << exp_id;
      step();
      vectors++; if (grant_id !== ID_W'(exp_id)) begin miscompares++; $display("FAIL fair_grant[%0d]: got %0d exp %0d", f, grant_id, exp_id); end
      vectors++; if (tx_data !== 8'h10 + 8'(exp_id)) begin miscompares++; $display("FAIL fair_data[%0d]: got %h exp %h", f, tx_data, 8'h10 + 8'(exp_id)); end
      vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL fair_ready[%0d]: got %b exp %b", f, req_ready, exp_rdy); end
      step();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      vectors++; if (tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL fair_gap[%0d]: got %b exp 0", f, tx_en_sig); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_watchdog();
    int hi_cnt;
    int err_cnt;
    req_data  = 32'h0077_005A;
    req_valid = 4'b0001;
    step();
    vectors++; if (grant_id !== 2'd0 || tx_data !== 8'h5A || tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL wd_grant: got id=%0d data=%h en=%b exp 0 5a 1", grant_id, tx_data, tx_en_sig); end
    req_valid = 4'b0100;
    hi_cnt  = 1;
    err_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tx_en_sig === 1'b1) hi_cnt++;
      if (timeout_err === 1'b1) err_cnt++;
    end
    vectors++; if (hi_cnt != 100) begin miscompares++; $display("FAIL wd_en_cycles: got %0d exp 100", hi_cnt); end
    vectors++; if (timeout_err !== 1'b1 || tx_en_sig !== 1'b0) begin miscompares++; $display("FAIL wd_abort: got err=%b en=%b exp 1 0", timeout_err, tx_en_sig); end
    step();
    if (timeout_err === 1'b1) err_cnt++;
    vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL wd_err_pulses: got %0d exp 1", err_cnt); end
    vectors++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL wd_idle: got busy=%b err=%b exp 0 0", busy, timeout_err); end
    step();
    vectors++; if (grant_id !== 2'd2 || tx_data !== 8'h77 || tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL wd_pending: got id=%0d data=%h en=%b exp 2 77 1", grant_id, tx_data, tx_en_sig); end
    req_valid = 4'b0000;
    step();
    finish_frame();
  endtask

  task automatic test_coincident();
    req_data  = 32'h0000_3C00;
    req_valid = 4'b0010;
    step();
    vectors++; if (grant_id !== 2'd1 || tx_data !== 8'h3C) begin miscompares++; $display("FAIL coin_grant: got id=%0d data=%h exp 1 3c", grant_id, tx_data); end
    req_valid = 4'b0000;
    repeat (99) step();
    vectors++; if (tx_en_sig !== 1'b1 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL coin_before: got en=%b err=%b exp 1 0", tx_en_sig, timeout_err); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL coin_err: got %b exp 0", timeout_err); end
    vectors++; if (tx_en_sig !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL coin_gap: got en=%b busy=%b exp 0 1", tx_en_sig, busy); end
    step();
    vectors++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL coin_idle: got err=%b busy=%b exp 0 0", timeout_err, busy); end
  endtask

  task automatic test_reset_mid();
    req_data  = 32'h0000_00C3;
    req_valid = 4'b0001;
    step();
    vectors++; if (grant_id !== 2'd0 || tx_en_sig !== 1'b1) begin miscompares++; $display("FAIL rmid_grant: got id=%0d en=%b exp 0 1", grant_id, tx_en_sig); end
    req_valid = 4'b0000;
    repeat (50) step();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (tx_en_sig !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got en=%b busy=%b exp 0 0", tx_en_sig, busy); end
    vectors++; if (tx_data !== 8'h00 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL rmid_clear: got data=%h err=%b exp 00 0", tx_data, timeout_err); end
    step();
    rst_n     = 1'b1;
    req_data  = 32'h0022_00C3;
    req_valid = 4'b0101;
    step();
    vectors++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_prio: got id=%0d ready=%b exp 0 0001", grant_id, req_ready); end
    vectors++; if (tx_data !== 8'hC3 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL rmid_data: got data=%h err=%b exp c3 0", tx_data, timeout_err); end
    req_valid = 4'b0100;
    step();
    finish_frame();
    step();
    vectors++; if (grant_id !== 2'd2 || req_ready !== 4'b0100 || tx_data !== 8'h22) begin miscompares++; $display("FAIL rmid_next: got id=%0d ready=%b data=%h exp 2 0100 22", grant_id, req_ready, tx_data); end
    req_valid = 4'b0000;
    step();
    finish_frame();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_watchdog();
    test_coincident();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART byte transmitter (8N1 frame engine with tx_en_sig / tx_data / tx_done handshake) between N_REQ byte producers.
- Captures one byte from the winning requester and holds tx_en_sig and tx_data stable for the whole frame.
- Releases the transmitter on its one-cycle tx_done pulse.
- A watchdog aborts a frame whose tx_done never arrives.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CLKS, 16'd5000, clocks in SEND before abort; must exceed BPS*10+3 of the attached transmitter (4343 at 50 MHz / 115200).
- ID_W, derived localparam = clog2(N_REQ), minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  request bit per requester; held until its req_ready pulse
- req_data  in  8*N_REQ  byte per requester; requester k uses bits [8k+7:8k]
- req_ready  out  N_REQ  one-cycle accept pulse, at most one bit set
- tx_en_sig  out  1  enable to transmitter, registered
- tx_data  out  8  byte to transmitter, registered, stable while tx_en_sig=1
- tx_done  in  1  one-cycle frame-complete pulse from transmitter
- grant_id  out  ID_W  index of current/last granted requester
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; tx_en_sig=0, tx_data=0, req_ready=0, grant_id=0, timeout_err=0, busy=0.
  - Timer=0; last_grant=N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, SEND, GAP. Encoding is binary, 2 bits.
- IDLE, on an edge with any req_valid bit set:
  - Winner k is the first set bit scanning last_grant+1, last_grant+2, ... modulo N_REQ.
  - Same edge: tx_data<=req_data[k], tx_en_sig<=1, req_ready[k]<=1, grant_id<=k, last_grant<=k, timer<=0, state->SEND.
  - Latency from req_valid seen to tx_en_sig high is 1 clk.
  - With no req_valid set, IDLE holds and all outputs keep their values except req_ready=0.
- SEND:
  - req_ready returns to 0 after one cycle.
  - tx_en_sig and tx_data are unchanged every cycle.
  - Timer increments by 1 each clk, 16-bit, and saturates rather than wrapping.
  - tx_done=1 sampled: tx_en_sig<=0, state->GAP. tx_en_sig stays high on the sampling edge itself, so the transmitter completes its clear-done step.
  - Timer==TIMEOUT_CLKS-1 with tx_done=0: tx_en_sig<=0, timeout_err<=1 for one cycle, state->GAP.
  - tx_done and timeout on the same edge: tx_done wins; no error is flagged.
- GAP:
  - Exactly one clk with tx_en_sig=0, guaranteeing a transmitter restart from its first state.
  - timeout_err clears; state->IDLE.
  - New arbitration happens in IDLE, so frame-to-frame spacing is ≥2 clk of enable-low.
- tx_done sampled in IDLE or GAP is ignored.
- Dropping req_valid[k] after its req_ready pulse has no effect on the current frame, because data is already captured.
- req_valid dropped before grant: that requester simply is not selected.
- Reset mid-SEND:
  - tx_en_sig falls asynchronously; the transmitter resets in parallel on the shared rst_n.
  - The aborted byte is not retried and no timeout_err is raised.
- Fairness: with all N_REQ valid continuously, the grant sequence is 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 frames.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants ST_IDLE=0, ST_SEND=1, ST_GAP=2.
  - Baud constants BPS_50MHz_115200=434, BPS_50MHz_9600=5208, BPS_12MHz_115200=104, BPS_12MHz_9600=1250.
  - Helper for the default timeout, BPS*10+slack.
- One natural sub-module: uart_rr_pick.
  - Purely combinational rotate-priority-encoder.
  - Inputs: req vector, last_grant. Outputs: any, winner index.
  - Instantiated once; everything else stays in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 → next clk req_ready=4'b0100 and grant_id=2, tx_data=8'hA5, tx_en_sig=1; with the real transmitter at BPS=434, tx_pin shows start bit, then 1,0,1,0,0,1,0,1 (LSB first), then stop; tx_en_sig falls the clk after tx_done.
- Simultaneous requests after reset: req_valid=4'b1010 → requester 1 granted first, requester 3 second; two complete frames; ≥2 enable-low clks between them.
- Fairness: all four valid continuously for 8 frames with distinct bytes 8'h10..8'h13 → grant_id sequence 0,1,2,3,0,1,2,3 and each byte matches its owner.
- Watchdog: stub transmitter never asserts tx_done, TIMEOUT_CLKS=16'd100 → tx_en_sig high exactly 100 clks, timeout_err pulses once, then IDLE; a pending request is granted after GAP.
- tx_done and timeout coincident: stub raises tx_done on the same edge the timer reaches TIMEOUT_CLKS-1 → timeout_err stays 0 and the normal GAP follows.
- Reset mid-SEND: assert rst_n=0 at clk 2000 of a frame → tx_en_sig=0 immediately, busy=0, last_grant=N_REQ-1; after release, requester 0 wins over a pending requester 2.
